// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding and
// default reset/halt constants.
package fetch_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          ADDR_BITS         = 10;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the combinational memory
// address and hands fetched words to decode through a one-entry output slot.
module fetch_controller
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted,
  output logic [31:0] fetch_count
);

  state_t      state;
  logic [31:0] pc;
  logic        handshake;
  logic        slot_free;

  // Memory address is the PC itself; the memory indexes its own low bits.
  assign imem_addr = pc;
  assign handshake = inst_valid & inst_ready;
  assign slot_free = ~inst_valid | inst_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      inst_out    <= 32'd0;
      inst_pc     <= 32'd0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      // A word consumed in the same cycle as a flush still counts as delivered.
      if (handshake) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            pc    <= RESET_PC;
            state <= RUN;
          end
        end

        RUN: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            pc         <= redirect_pc;
          end else if (slot_free) begin
            inst_out   <= imem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            // The halt word is delivered, but the PC parks on it.
            if (imem_data == HALT_WORD) begin
              state <= DRAIN;
            end else begin
              pc <= pc + 32'd1;
            end
          end
        end

        DRAIN: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            pc         <= redirect_pc;
            state      <= RUN;
          end else if (handshake) begin
            inst_valid <= 1'b0;
            halted     <= 1'b1;
            state      <= HALTED;
          end
        end

        HALTED: begin
          if (redirect_valid) begin
            pc     <= redirect_pc;
            halted <= 1'b0;
            state  <= RUN;
          end else if (start) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            state  <= RUN;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the 1024-word instruction memory: owns the program counter, drives the memory's combinational read address, and delivers fetched words to decode through a one-entry registered output slot with a valid/ready handshake. Handles start-up, branch/jump redirects with flush, decode back-pressure, and halting on a designated halt word. Sits between the instruction memory (address out, data back same cycle) and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset and after `start` from HALTED (word index)
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch
- ADDR_BITS, 10, low PC bits used to index instruction memory (1024 words)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  leave IDLE/HALTED and begin fetching at RESET_PC
- redirect_valid  in  1  branch/jump taken; flush slot, load PC
- redirect_pc  in  32  target word index for redirect
- imem_addr  out  32  read address to instruction memory (= pc register)
- imem_data  in  32  instruction at imem_addr, valid same cycle
- inst_valid  out  1  output slot holds a fetched instruction
- inst_out  out  32  fetched instruction word
- inst_pc  out  32  PC of inst_out
- inst_ready  in  1  decode accepts slot this cycle
- halted  out  1  FSM in HALTED
- fetch_count  out  32  number of instructions delivered (handshakes completed)

## Operation
- States: IDLE, RUN, DRAIN, HALTED. Reset → IDLE, pc=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, halted=0, fetch_count=0.
- IDLE: no fetch. `start` → RUN. redirect_valid in IDLE ignored.
- RUN: slot "free" when inst_valid=0 or (inst_valid & inst_ready). If free: slot ← {imem_data, pc}, inst_valid←1, pc←pc+1. If not free: slot and pc hold (stall).
- Fetched word == HALT_WORD: loaded into slot as normal, pc not incremented, RUN → DRAIN.
- DRAIN: no fetch; when slot accepted (inst_valid & inst_ready) → HALTED, inst_valid←0.
- HALTED: halted=1, no fetch. `start` → RUN with pc←RESET_PC; redirect_valid → RUN with pc←redirect_pc. Both together: redirect wins.
- Redirect (RUN or DRAIN): inst_valid←0 (slot flushed, not counted), pc←redirect_pc, state←RUN. Priority over fetch, stall, and halt detection in the same cycle.
- fetch_count increments by 1 on every inst_valid & inst_ready, including a handshake in the redirect cycle (decode consumed it before flush); wraps modulo 2^32.
- PC arithmetic: 32-bit, +1 per fetch, wraps 32'hFFFF_FFFF → 0. Memory indexed by pc[ADDR_BITS-1:0]; aliasing above 1023 is intended, inst_pc carries the full 32-bit pc.
- rst_n low mid-operation: all state returns to reset values on that edge regardless of other inputs.

## Timing
- imem_addr combinational from pc register; memory data sampled same cycle.
- start high in cycle N (IDLE) → imem_addr=RESET_PC in N+1 → inst_valid=1 in N+2.
- Throughput 1 instruction/cycle with inst_ready held high.
- Redirect in cycle N → inst_valid=0 in N+1, imem_addr=redirect_pc in N+1, target instruction valid in N+2 (one bubble).
- inst_out/inst_pc stable while inst_valid & !inst_ready.
- halted rises the cycle after the HALT_WORD slot is accepted.

## Structure
- Shared package `fetch_defs`: state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, HALTED=2'd3), HALT_WORD default, RESET_PC default.
- One flat module; no sub-module. Output slot and FSM live in fetch_controller; instruction memory stays a separate instance in the top level.

## Test plan
- Reset then start, memory words 0..3 = 0x11,0x22,0x33,0x44, inst_ready=1 → inst_valid from cycle 2, inst_out 0x11,0x22,0x33,0x44 on consecutive cycles, inst_pc 0..3, fetch_count=4.
- inst_ready low 3 cycles at word 2 → inst_out=0x33, inst_pc=2 held 3 cycles, imem_addr=3 held, no word lost or duplicated.
- redirect_valid with redirect_pc=0x100 while slot holds pc 5 and inst_ready=0 → slot flushed, next valid inst_pc=0x100, fetch_count unchanged.
- Word 3 = HALT_WORD → delivered with inst_pc=3, no fetch of pc 4, halted=1 the cycle after acceptance; start → restart at RESET_PC.
- pc=32'hFFFF_FFFF via redirect → next inst_pc=0 after wrap; redirect_pc=0x400 fetches memory word 0 with inst_pc=0x400.
- rst_n low mid-stream with inst_valid=1 → next cycle inst_valid=0, pc=RESET_PC, fetch_count=0, state IDLE (no fetch until start).
